// File: rtl/keccak_stream_buffer_if.sv
// Handshake bundle between the host word stream, the Keccak-f[1600] core and
// the digest consumer. The buffer connects through the master modport; the
// surrounding environment (host, permutation core, consumer) uses slave.
interface keccak_stream_buffer_if #(
  parameter int unsigned IN_W  = 64,
  parameter int unsigned OUT_W = 64,
  parameter int unsigned RATE  = 1088
);
  logic [IN_W-1:0]  Din;
  logic             Din_valid;
  logic             Din_last;
  logic             Din_ready;
  logic [RATE-1:0]  Block_out;
  logic             Block_valid;
  logic             Block_last;
  logic             Block_ready;
  logic [RATE-1:0]  Perm_in;
  logic             Perm_in_valid;
  logic             Squeeze_req;
  logic [OUT_W-1:0] Dout;
  logic             Dout_valid;
  logic             Dout_ready;
  logic             Busy;

  modport master (
    input  Din, Din_valid, Din_last,
    output Din_ready,
    output Block_out, Block_valid, Block_last,
    input  Block_ready,
    input  Perm_in, Perm_in_valid,
    output Squeeze_req,
    output Dout, Dout_valid,
    input  Dout_ready,
    output Busy
  );

  modport slave (
    output Din, Din_valid, Din_last,
    input  Din_ready,
    input  Block_out, Block_valid, Block_last,
    output Block_ready,
    output Perm_in, Perm_in_valid,
    input  Squeeze_req,
    input  Dout, Dout_valid,
    output Dout_ready,
    input  Busy
  );
endinterface

// File: rtl/keccak_stream_buffer.sv
// Absorb/squeeze buffer for a Keccak-f[1600] core: packs IN_W-bit words into
// RATE-bit blocks, then streams OUT_LEN bits of digest as OUT_W-bit words,
// requesting extra permutations when OUT_LEN exceeds RATE.
// Optional pad10*1 padding is enabled by defining KECCAK_STREAM_BUFFER_PAD_EN;
// otherwise a short final block is zero-filled.
module keccak_stream_buffer #(
  parameter int unsigned IN_W    = 64,
  parameter int unsigned OUT_W   = 64,
  parameter int unsigned RATE    = 1088,
  parameter int unsigned OUT_LEN = 256,
  parameter logic [7:0]  DSBYTE  = 8'h06
) (
  input  logic                  Clock,
  input  logic                  Reset,
  keccak_stream_buffer_if.master bus
);

  localparam int unsigned NW_IN  = RATE / IN_W;
  localparam int unsigned NW_OUT = RATE / OUT_W;
  localparam int unsigned NW_TOT = OUT_LEN / OUT_W;
  localparam int unsigned CIW    = $clog2(NW_IN) + 1;
  localparam int unsigned COW    = $clog2(NW_OUT) + 1;
  localparam int unsigned CTW    = $clog2(NW_TOT) + 1;
  localparam int unsigned AW     = $clog2(RATE);

  typedef enum logic [2:0] {
    S_FILL,
    S_BLOCK,
    S_WAIT_PERM,
    S_SQUEEZE,
    S_REQ
  } state_t;

  state_t           r_state;
  logic [CIW-1:0]   r_cnt_in;
  logic [COW-1:0]   r_cnt_out;
  logic [CTW-1:0]   r_cnt_tot;
  logic [RATE-1:0]  r_block;
  logic [RATE-1:0]  r_shift;
  logic             r_din_ready;
  logic             r_block_valid;
  logic             r_block_last;
  logic             r_squeeze_req;
  logic             r_dout_valid;

  logic [RATE-1:0]  w_block_wr;
  logic [AW-1:0]    w_lo;
  logic             w_din_fire;
  logic             w_at_end;

`ifdef KECCAK_STREAM_BUFFER_PAD_EN
  localparam logic [RATE-1:0] PAD_BLOCK = {1'b1, {(RATE-9){1'b0}}, DSBYTE};
  logic             r_pad_pend;
  logic [AW-1:0]    w_pad_lo;
  assign w_pad_lo = w_lo + AW'(IN_W);
`else
  logic             w_unused_dsbyte;
  assign w_unused_dsbyte = ^DSBYTE;
`endif

  assign w_lo       = AW'(r_cnt_in) * AW'(IN_W);
  assign w_din_fire = bus.Din_valid && r_din_ready;
  assign w_at_end   = (r_cnt_in == CIW'(NW_IN - 1));

  assign bus.Din_ready   = r_din_ready;
  assign bus.Block_out   = r_block;
  assign bus.Block_valid = r_block_valid;
  assign bus.Block_last  = r_block_last;
  assign bus.Squeeze_req = r_squeeze_req;
  assign bus.Dout        = r_shift[OUT_W-1:0];
  assign bus.Dout_valid  = r_dout_valid;
  assign bus.Busy        = !((r_state == S_FILL) && (r_cnt_in == '0));

  // Next block contents when the current input word is written (plus padding).
  always_comb begin
    w_block_wr = r_block;
    w_block_wr[w_lo +: IN_W] = bus.Din;
`ifdef KECCAK_STREAM_BUFFER_PAD_EN
    if (bus.Din_last && !w_at_end) begin
      w_block_wr[w_pad_lo +: 8] = DSBYTE;
      w_block_wr[RATE-1]        = ~w_block_wr[RATE-1];
    end
`endif
  end

  // Absorb/squeeze control FSM with registered handshake outputs.
  // The block register is cleared whenever a block leaves, so a short final
  // block is zero-filled without a separate fill pass.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state       <= S_FILL;
      r_cnt_in      <= '0;
      r_cnt_out     <= '0;
      r_cnt_tot     <= '0;
      r_block       <= '0;
      r_shift       <= '0;
      r_din_ready   <= 1'b0;
      r_block_valid <= 1'b0;
      r_block_last  <= 1'b0;
      r_squeeze_req <= 1'b0;
      r_dout_valid  <= 1'b0;
`ifdef KECCAK_STREAM_BUFFER_PAD_EN
      r_pad_pend    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FILL: begin
          r_din_ready <= 1'b1;
          if (w_din_fire) begin
            r_block  <= w_block_wr;
            r_cnt_in <= r_cnt_in + 1'b1;
            if (w_at_end || bus.Din_last) begin
              r_state       <= S_BLOCK;
              r_din_ready   <= 1'b0;
              r_block_valid <= 1'b1;
`ifdef KECCAK_STREAM_BUFFER_PAD_EN
              // A message ending exactly on a block boundary gets a trailing
              // all-padding block, which then carries the last flag.
              r_block_last  <= bus.Din_last && !w_at_end;
              r_pad_pend    <= bus.Din_last && w_at_end;
`else
              r_block_last  <= bus.Din_last;
`endif
            end
          end
        end

        S_BLOCK: begin
          if (bus.Block_ready) begin
`ifdef KECCAK_STREAM_BUFFER_PAD_EN
            if (r_pad_pend) begin
              r_block      <= PAD_BLOCK;
              r_block_last <= 1'b1;
              r_pad_pend   <= 1'b0;
            end else
`endif
            if (r_block_last) begin
              r_state       <= S_WAIT_PERM;
              r_block       <= '0;
              r_block_valid <= 1'b0;
              r_block_last  <= 1'b0;
              r_cnt_in      <= '0;
              r_cnt_tot     <= '0;
            end else begin
              r_state       <= S_FILL;
              r_block       <= '0;
              r_block_valid <= 1'b0;
              r_cnt_in      <= '0;
              r_din_ready   <= 1'b1;
            end
          end
        end

        S_WAIT_PERM: begin
          if (bus.Perm_in_valid) begin
            r_shift      <= bus.Perm_in;
            r_cnt_out    <= '0;
            r_dout_valid <= 1'b1;
            r_state      <= S_SQUEEZE;
          end
        end

        S_SQUEEZE: begin
          if (bus.Dout_ready) begin
            r_shift   <= r_shift >> OUT_W;
            r_cnt_out <= r_cnt_out + 1'b1;
            r_cnt_tot <= r_cnt_tot + 1'b1;
            if (r_cnt_tot == CTW'(NW_TOT - 1)) begin
              r_shift      <= '0;
              r_dout_valid <= 1'b0;
              r_din_ready  <= 1'b1;
              r_state      <= S_FILL;
            end else if (r_cnt_out == COW'(NW_OUT - 1)) begin
              r_dout_valid  <= 1'b0;
              r_squeeze_req <= 1'b1;
              r_state       <= S_REQ;
            end
          end
        end

        S_REQ: begin
          r_squeeze_req <= 1'b0;
          r_state       <= S_WAIT_PERM;
        end

        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_stream_buffer.sv
// Scoreboard bench for keccak_stream_buffer: stimulus pushes expected blocks
// and digest words into queues, monitors pop and compare on each transfer.
// Instance A uses OUT_LEN=256, instance B uses OUT_LEN=2176 (two-block squeeze).
`timescale 1ns/1ps
module tb_keccak_stream_buffer;
  localparam int unsigned IN_W  = 64;
  localparam int unsigned OUT_W = 64;
  localparam int unsigned RATE  = 1088;
  localparam int NL = 17;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  keccak_stream_buffer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .RATE(RATE)) ia();
  keccak_stream_buffer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .RATE(RATE)) ib();

  keccak_stream_buffer #(.IN_W(IN_W), .OUT_W(OUT_W), .RATE(RATE), .OUT_LEN(256), .DSBYTE(8'h06))
    dut_a (.Clock(clk), .Reset(rst_a), .bus(ia));
  keccak_stream_buffer #(.IN_W(IN_W), .OUT_W(OUT_W), .RATE(RATE), .OUT_LEN(2176), .DSBYTE(8'h06))
    dut_b (.Clock(clk), .Reset(rst_b), .bus(ib));

  typedef struct packed {
    logic [RATE-1:0] data;
    logic            last;
  } blk_t;

  int total = 0;
  int bad   = 0;
  blk_t        exp_blk_a[$];
  logic [63:0] exp_dout_a[$];
  logic [63:0] exp_dout_b[$];
  int nblk_a = 0, last_blk_a = 0, ndout_a = 0, ndout_b = 0, nsq_a = 0, nsq_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait expired, event not seen", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Block monitor for instance A
  always @(negedge clk) begin : mon_blk_a
    blk_t e;
    if (ia.Block_valid && ia.Block_ready) begin
      if (exp_blk_a.size() == 0) begin
        timeout("blk_a_unexpected");
      end else begin
        e = exp_blk_a.pop_front();
        for (int l = 0; l < NL; l++)
          check($sformatf("blk%0d_lane%0d", nblk_a, l), ia.Block_out[l*64 +: 64], e.data[l*64 +: 64]);
        check($sformatf("blk%0d_last", nblk_a), 64'(ia.Block_last), 64'(e.last));
        if (e.last) last_blk_a++;
        nblk_a++;
      end
    end
  end

  // Digest monitor for instance A
  always @(negedge clk) begin : mon_dout_a
    logic [63:0] e;
    if (ia.Squeeze_req) nsq_a++;
    if (ia.Dout_valid && ia.Dout_ready) begin
      if (exp_dout_a.size() == 0) begin
        timeout("dout_a_unexpected");
      end else begin
        e = exp_dout_a.pop_front();
        check($sformatf("dout_a%0d", ndout_a), ia.Dout, e);
      end
      ndout_a++;
    end
  end

  // Digest and squeeze-request monitor for instance B
  always @(negedge clk) begin : mon_dout_b
    logic [63:0] e;
    if (ib.Squeeze_req) begin
      nsq_b++;
      check("sq_b_after_words", 64'(ndout_b), 64'd17);
    end
    if (ib.Dout_valid && ib.Dout_ready) begin
      if (exp_dout_b.size() == 0) begin
        timeout("dout_b_unexpected");
      end else begin
        e = exp_dout_b.pop_front();
        check($sformatf("dout_b%0d", ndout_b), ib.Dout, e);
      end
      ndout_b++;
    end
  end

  task automatic send_a(input logic [63:0] d, input logic l);
    int n = 0;
    ia.Din = d; ia.Din_valid = 1'b1; ia.Din_last = l;
    @(negedge clk);
    while (!ia.Din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ia.Din_ready) timeout("din_a_ready");
    tick();
    ia.Din_valid = 1'b0; ia.Din_last = 1'b0;
  endtask

  // Send words base+1..base+n with Din_last on the final one.
  task automatic msg_a(input int n, input logic [63:0] base);
    blk_t e;
    e.data = '0;
    for (int i = 0; i < n; i++) e.data[i*64 +: 64] = base + 64'(i + 1);
`ifdef KECCAK_STREAM_BUFFER_PAD_EN
    if (n < NL) begin
      e.data[n*64 +: 8] = 8'h06;
      e.data[RATE-1]    = ~e.data[RATE-1];
      e.last = 1'b1;
      exp_blk_a.push_back(e);
    end else begin
      e.last = 1'b0;
      exp_blk_a.push_back(e);
      e.data = '0;
      e.data[7:0] = 8'h06;
      e.data[RATE-1] = 1'b1;
      e.last = 1'b1;
      exp_blk_a.push_back(e);
    end
`else
    e.last = 1'b1;
    exp_blk_a.push_back(e);
`endif
    for (int i = 0; i < n; i++) send_a(base + 64'(i + 1), (i == n - 1));
  endtask

  task automatic accept_a();
    int n = 0;
    int tgt = last_blk_a + 1;
    ia.Block_ready = 1'b1;
    while (last_blk_a < tgt && n < 50) begin
      tick();
      n++;
    end
    ia.Block_ready = 1'b0;
    if (last_blk_a < tgt) timeout("blk_a_accept");
  endtask

  task automatic perm_a(input logic [63:0] base);
    for (int l = 0; l < NL; l++) ia.Perm_in[l*64 +: 64] = base + 64'(l);
    for (int i = 0; i < 4; i++) exp_dout_a.push_back(base + 64'(i));
    ia.Perm_in_valid = 1'b1;
    tick();
    ia.Perm_in_valid = 1'b0;
  endtask

  task automatic perm_b(input logic [63:0] base);
    for (int l = 0; l < NL; l++) ib.Perm_in[l*64 +: 64] = base + 64'(l);
    for (int i = 0; i < NL; i++) exp_dout_b.push_back(base + 64'(i));
    ib.Perm_in_valid = 1'b1;
    tick();
    ib.Perm_in_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int tgt;
    rst_a = 1'b1; rst_b = 1'b1;
    ia.Din = '0; ia.Din_valid = 1'b0; ia.Din_last = 1'b0; ia.Block_ready = 1'b0;
    ia.Perm_in = '0; ia.Perm_in_valid = 1'b0; ia.Dout_ready = 1'b0;
    ib.Din = '0; ib.Din_valid = 1'b0; ib.Din_last = 1'b0; ib.Block_ready = 1'b1;
    ib.Perm_in = '0; ib.Perm_in_valid = 1'b0; ib.Dout_ready = 1'b1;

    // Reset state
    tick(); tick();
    @(negedge clk);
    check("rst_din_ready", 64'(ia.Din_ready), 64'd0);
    check("rst_block_valid", 64'(ia.Block_valid), 64'd0);
    check("rst_block_last", 64'(ia.Block_last), 64'd0);
    check("rst_squeeze_req", 64'(ia.Squeeze_req), 64'd0);
    check("rst_dout_valid", 64'(ia.Dout_valid), 64'd0);
    check("rst_busy", 64'(ia.Busy), 64'd0);
    check("rst_block_lane0", ia.Block_out[63:0], 64'd0);
    check("rst_dout", ia.Dout, 64'd0);
    tick();
    rst_a = 1'b0; rst_b = 1'b0;
    tick(); tick();

    // Din_last without Din_valid, and Perm_in_valid while filling, are ignored
    ia.Din_last = 1'b1;
    for (int l = 0; l < NL; l++) ia.Perm_in[l*64 +: 64] = 64'hDEAD_0000_0000_0000 + 64'(l);
    ia.Perm_in_valid = 1'b1;
    tick();
    ia.Perm_in_valid = 1'b0;
    tick(); tick();
    ia.Din_last = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(ia.Busy), 64'd0);
    check("idle_dout_valid", 64'(ia.Dout_valid), 64'd0);
    check("idle_block_valid", 64'(ia.Block_valid), 64'd0);
    check("idle_din_ready", 64'(ia.Din_ready), 64'd1);
    tick();

    // Full message 1..17, held block with ignored Din pulses
    msg_a(NL, 64'd0);
    for (int i = 0; i < 10; i++) begin
      ia.Din = 64'hBAD0 + 64'(i);
      ia.Din_valid = (i % 2 == 0);
      @(negedge clk);
      check("hold_block_valid", 64'(ia.Block_valid), 64'd1);
      check("hold_din_ready", 64'(ia.Din_ready), 64'd0);
      check("hold_lane0", ia.Block_out[63:0], 64'd1);
      check("hold_lane16", ia.Block_out[1087:1024], 64'd17);
      tick();
    end
    ia.Din_valid = 1'b0;
    accept_a();

    // Squeeze lanes 0..3 with Dout_ready toggling
    perm_a(64'd0);
    tgt = ndout_a + 4;
    n = 0;
    while (ndout_a < tgt && n < 60) begin
      ia.Dout_ready = (n % 2 == 0);
      @(negedge clk);
      if (!ia.Dout_ready && ndout_a < tgt) check("stall_dout_valid", 64'(ia.Dout_valid), 64'd1);
      tick();
      n++;
    end
    ia.Dout_ready = 1'b0;
    if (ndout_a < tgt) timeout("squeeze_a1");
    tick();
    @(negedge clk);
    check("post_sq_busy", 64'(ia.Busy), 64'd0);
    check("post_sq_dout_valid", 64'(ia.Dout_valid), 64'd0);
    tick();

    // Short message of 3 words, continuous output
    msg_a(3, 64'd0);
    accept_a();
    perm_a(64'hA5A5_0000_0000_0000);
    ia.Dout_ready = 1'b1;
    tgt = ndout_a + 4;
    n = 0;
    while (ndout_a < tgt && n < 40) begin
      tick();
      n++;
    end
    ia.Dout_ready = 1'b0;
    if (ndout_a < tgt) timeout("squeeze_a2");
    tick();

    // Reset with 5 words buffered, then a clean 17-word message
    for (int i = 0; i < 5; i++) send_a(64'd100 + 64'(i), 1'b0);
    @(negedge clk);
    check("pre_rst_busy", 64'(ia.Busy), 64'd1);
    tick();
    rst_a = 1'b1;
    #1;
    check("mid_rst_busy", 64'(ia.Busy), 64'd0);
    check("mid_rst_din_ready", 64'(ia.Din_ready), 64'd0);
    check("mid_rst_block_valid", 64'(ia.Block_valid), 64'd0);
    check("mid_rst_lane0", ia.Block_out[63:0], 64'd0);
    check("mid_rst_lane4", ia.Block_out[319:256], 64'd0);
    check("mid_rst_dout_valid", 64'(ia.Dout_valid), 64'd0);
    tick(); tick();
    rst_a = 1'b0;
    tick();
    msg_a(NL, 64'd200);
    accept_a();
    tick();
    check("a_blk_queue_empty", 64'(exp_blk_a.size()), 64'd0);
    check("a_dout_queue_empty", 64'(exp_dout_a.size()), 64'd0);
    check("a_squeeze_reqs", 64'(nsq_a), 64'd0);

    // Instance B: one-word message, 2176-bit output over two permutations
    ib.Din = 64'h55; ib.Din_valid = 1'b1; ib.Din_last = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ib.Din_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ib.Din_ready) timeout("din_b_ready");
    tick();
    ib.Din_valid = 1'b0; ib.Din_last = 1'b0;
    tick(); tick(); tick();
    perm_b(64'h1000);
    n = 0;
    while (nsq_b < 1 && n < 100) begin
      tick();
      n++;
    end
    if (nsq_b < 1) timeout("squeeze_req_b");
    perm_b(64'h2000);
    n = 0;
    while (ndout_b < 34 && n < 100) begin
      tick();
      n++;
    end
    if (ndout_b < 34) timeout("squeeze_b");
    for (int i = 0; i < 40; i++) tick();
    @(negedge clk);
    check("b_squeeze_reqs", 64'(nsq_b), 64'd1);
    check("b_words", 64'(ndout_b), 64'd34);
    check("b_queue_empty", 64'(exp_dout_b.size()), 64'd0);
    check("b_busy", 64'(ib.Busy), 64'd0);
    check("b_dout_valid", 64'(ib.Dout_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
